// File: rtl/mono_select_stack.sv
`default_nettype none
// ============================================================================
// Module      : mono_select_stack
// Description : Monotonic selection stack. It keeps the best MAX_CAP-element
//               ordered subsequence of a value stream in keep-max or keep-min
//               mode. Pops run one per cycle and stall the input. The result
//               drains bottom-to-top over a ready/valid port.
//               Optional feature macro: MONO_STACK_DECIMAL_EN adds a decimal
//               accumulator over the drained digits (out_value/out_value_valid).
// Revision    : 1.0 - initial release
// ============================================================================
module mono_select_stack #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_CAP    = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic [CNT_WIDTH-1:0]    nums_left,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [$clog2(MAX_CAP):0] size,
    output logic                    full,
    output logic                    empty
`ifdef MONO_STACK_DECIMAL_EN
    ,
    output logic [63:0]             out_value,
    output logic                    out_value_valid
`endif
);

    localparam int c_SIZE_W = $clog2(MAX_CAP) + 1;
    localparam int c_SUM_W  = CNT_WIDTH + 1;

    localparam logic [1:0] c_ST_ACCEPT = 2'd0;
    localparam logic [1:0] c_ST_POP    = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [MAX_CAP];
    logic [c_SIZE_W-1:0]   r_size;
    logic [c_SIZE_W-1:0]   r_rd_idx;
    logic                  r_mode;
    logic                  r_first;
    logic [DATA_WIDTH-1:0] r_held_x;
    logic [CNT_WIDTH-1:0]  r_held_n;
    logic                  r_held_last;

    logic [DATA_WIDTH-1:0] w_x;
    logic [CNT_WIDTH-1:0]  w_n;
    logic                  w_mode_eff;
    logic [c_SIZE_W-1:0]   w_top_idx;
    logic [DATA_WIDTH-1:0] w_top;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [c_SUM_W-1:0]    w_sum;
    logic                  w_beats;
    logic                  w_pop_cond;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_latch;
    logic                  w_out_fire;

    // In POP the held element is re-evaluated; otherwise the live input is.
    assign w_x        = (r_state == c_ST_POP) ? r_held_x : in_data;
    assign w_n        = (r_state == c_ST_POP) ? r_held_n : nums_left;
    // Mode is taken live only on the first element of a sequence.
    assign w_mode_eff = (r_state == c_ST_ACCEPT && r_first) ? mode : r_mode;
    assign w_top_idx  = r_size - c_SIZE_W'(1);
    // One extra bit keeps size+n from wrapping.
    assign w_sum      = c_SUM_W'(w_n) + c_SUM_W'(r_size);
    assign w_beats    = w_mode_eff ? (w_top > w_x) : (w_top < w_x);
    assign w_pop_cond = !empty && (w_sum > c_SUM_W'(MAX_CAP)) && w_beats;

    assign size       = r_size;
    assign full       = (r_size == c_SIZE_W'(MAX_CAP));
    assign empty      = (r_size == '0);
    assign out_data   = out_valid ? w_rd_data : '0;
    assign out_last   = out_valid && (r_rd_idx == w_top_idx);
    assign w_out_fire = out_valid && out_ready;

    // Read muxes for the stack top and the drain pointer.
    always_comb begin
        w_top     = '0;
        w_rd_data = '0;
        for (int i = 0; i < MAX_CAP; i++) begin
            if (c_SIZE_W'(i) == w_top_idx) w_top = r_mem[i];
            if (c_SIZE_W'(i) == r_rd_idx)  w_rd_data = r_mem[i];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_ST_ACCEPT;
        else       r_state <= w_state_nxt;
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            c_ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_pop_cond) begin
                        w_pop       = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = c_ST_POP;
                    end else begin
                        w_push = !full;
                        if (in_last) w_state_nxt = c_ST_DRAIN;
                    end
                end
            end
            c_ST_POP: begin
                if (w_pop_cond) begin
                    w_pop = 1'b1;
                end else begin
                    w_push      = !full;
                    w_state_nxt = r_held_last ? c_ST_DRAIN : c_ST_ACCEPT;
                end
            end
            c_ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_last) w_state_nxt = c_ST_ACCEPT;
            end
            default: w_state_nxt = c_ST_ACCEPT;
        endcase
    end

    // Stack storage, occupancy, held element and drain pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_CAP; i++) r_mem[i] <= '0;
            r_size      <= '0;
            r_rd_idx    <= '0;
            r_mode      <= 1'b0;
            r_first     <= 1'b1;
            r_held_x    <= '0;
            r_held_n    <= '0;
            r_held_last <= 1'b0;
        end else begin
            if (w_pop) r_size <= r_size - c_SIZE_W'(1);
            if (w_push) begin
                for (int i = 0; i < MAX_CAP; i++) begin
                    if (c_SIZE_W'(i) == r_size) r_mem[i] <= w_x;
                end
                r_size <= r_size + c_SIZE_W'(1);
            end
            if (w_latch) begin
                r_held_x    <= in_data;
                r_held_n    <= nums_left;
                r_held_last <= in_last;
            end
            if (r_state == c_ST_ACCEPT && in_valid) begin
                r_first <= 1'b0;
                if (r_first) r_mode <= mode;
            end
            if (w_out_fire) begin
                if (out_last) begin
                    r_size   <= '0;
                    r_rd_idx <= '0;
                    r_first  <= 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + c_SIZE_W'(1);
                end
            end
        end
    end

`ifdef MONO_STACK_DECIMAL_EN
    logic [63:0] r_acc;
    logic        r_val_valid;

    assign out_value       = r_acc;
    assign out_value_valid = r_val_valid;

    // Decimal accumulation of drained digits; result flagged after last beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc       <= '0;
            r_val_valid <= 1'b0;
        end else begin
            r_val_valid <= w_out_fire && out_last;
            if (w_state_nxt == c_ST_DRAIN && r_state != c_ST_DRAIN) r_acc <= '0;
            else if (w_out_fire) r_acc <= r_acc * 64'd10 + 64'(out_data);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mono_select_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mono_select_stack
// Description : Directed self-checking bench. Three stack instances with
//               capacities 4, 2 and 3 share clock and reset; each sequence
//               uses hand-computed drain contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mono_select_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  in_valid, in_last, mode, out_ready;
    logic [63:0] in_data   [3];
    logic [15:0] nums_left [3];
    wire  [2:0]  in_ready, out_valid, out_last, full, empty;
    wire  [63:0] out_data  [3];
    wire  [2:0]  size_a;
    wire  [1:0]  size_b;
    wire  [2:0]  size_c;
`ifdef MONO_STACK_DECIMAL_EN
    wire  [63:0] out_value [3];
    wire  [2:0]  out_value_valid;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int st, em;

    always #5 clock = ~clock;

    mono_select_stack #(.DATA_WIDTH(64), .MAX_CAP(4), .CNT_WIDTH(16)) u_dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .nums_left(nums_left[0]), .mode(mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .size(size_a), .full(full[0]), .empty(empty[0])
`ifdef MONO_STACK_DECIMAL_EN
        , .out_value(out_value[0]), .out_value_valid(out_value_valid[0])
`endif
    );

    mono_select_stack #(.DATA_WIDTH(64), .MAX_CAP(2), .CNT_WIDTH(16)) u_dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .nums_left(nums_left[1]), .mode(mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .size(size_b), .full(full[1]), .empty(empty[1])
`ifdef MONO_STACK_DECIMAL_EN
        , .out_value(out_value[1]), .out_value_valid(out_value_valid[1])
`endif
    );

    mono_select_stack #(.DATA_WIDTH(64), .MAX_CAP(3), .CNT_WIDTH(16)) u_dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .nums_left(nums_left[2]), .mode(mode[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .size(size_c), .full(full[2]), .empty(empty[2])
`ifdef MONO_STACK_DECIMAL_EN
        , .out_value(out_value[2]), .out_value_valid(out_value_valid[2])
`endif
    );

    function automatic logic [63:0] sz(input int k);
        case (k)
            0:       return 64'(size_a);
            1:       return 64'(size_b);
            default: return 64'(size_c);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one element; report cycles stalled and cycles seen empty while waiting.
    task automatic send(input int k, input logic [63:0] x, input int n, input bit last,
                        output int stalls, output int empties);
        bit rdy;
        rdy          = 1'b0;
        in_valid[k]  = 1'b1;
        in_data[k]   = x;
        nums_left[k] = 16'(n);
        in_last[k]   = last;
        stalls       = 0;
        empties      = 0;
        for (int g = 0; g < 50; g++) begin
            rdy = in_ready[k];
            if (empty[k]) empties++;
            @(posedge clock); #1;
            if (rdy) break;
            stalls++;
        end
        if (!rdy) chk("send_timeout", 64'd0, 64'd1);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    // Wait for drain, consume cnt beats (optionally stalling 3 cycles at stall_at).
    task automatic drain(input int k, input logic [63:0] e [4], input int cnt,
                         input int stall_at, input logic [63:0] dec);
        int guard;
        guard = 0;
        while (!out_valid[k] && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        chk("drain_start", 64'(out_valid[k]), 64'd1);
        for (int i = 0; i < cnt; i++) begin
            if (i == stall_at) begin
                out_ready[k] = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clock); #1;
                    chk("hold_valid", 64'(out_valid[k]), 64'd1);
                    chk("hold_data", out_data[k], e[i]);
                    chk("hold_last", 64'(out_last[k]), 64'(i == cnt - 1));
                    chk("hold_in_ready", 64'(in_ready[k]), 64'd0);
                end
            end
            chk("beat_valid", 64'(out_valid[k]), 64'd1);
            chk("beat_data", out_data[k], e[i]);
            chk("beat_last", 64'(out_last[k]), 64'(i == cnt - 1));
            chk("beat_in_ready", 64'(in_ready[k]), 64'd0);
            out_ready[k] = 1'b1;
            @(posedge clock); #1;
            out_ready[k] = 1'b0;
        end
        chk("post_valid", 64'(out_valid[k]), 64'd0);
        chk("post_in_ready", 64'(in_ready[k]), 64'd1);
        chk("post_size", sz(k), 64'd0);
        chk("post_empty", 64'(empty[k]), 64'd1);
`ifdef MONO_STACK_DECIMAL_EN
        chk("dec_valid", 64'(out_value_valid[k]), 64'd1);
        chk("dec_value", out_value[k], dec);
        @(posedge clock); #1;
        chk("dec_pulse_end", 64'(out_value_valid[k]), 64'd0);
`else
        if (dec == 64'hFFFF_FFFF_FFFF_FFFF) $display("note: unexpected decimal sentinel");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e [4];
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        mode      = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_data[k]   = '0;
            nums_left[k] = '0;
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 64'(in_ready[k]), 64'd1);
            chk("rst_size", sz(k), 64'd0);
            chk("rst_empty", 64'(empty[k]), 64'd1);
            chk("rst_full", 64'(full[k]), 64'd0);
            chk("rst_out_valid", 64'(out_valid[k]), 64'd0);
            chk("rst_out_last", 64'(out_last[k]), 64'd0);
            chk("rst_out_data", out_data[k], 64'd0);
        end

        // Keep-max, capacity 4, with a 3-cycle downstream stall mid-drain.
        send(0, 64'd30, 6, 1'b0, st, em);
        chk("t1_first_stall", 64'(st), 64'd0);
        send(0, 64'd27, 5, 1'b0, st, em);
        send(0, 64'd25, 4, 1'b0, st, em);
        send(0, 64'd20, 3, 1'b0, st, em);
        chk("t1_full", 64'(full[0]), 64'd1);
        send(0, 64'd16, 2, 1'b0, st, em);
        chk("t1_discard_size", sz(0), 64'd4);
        send(0, 64'd25, 1, 1'b1, st, em);
        chk("t1_pop_in_ready", 64'(in_ready[0]), 64'd0);
        chk("t1_pop_size", sz(0), 64'd3);
        @(posedge clock); #1;
        chk("t1_drain_valid", 64'(out_valid[0]), 64'd1);
        chk("t1_drain_size", sz(0), 64'd4);
        e = '{64'd30, 64'd27, 64'd25, 64'd25};
        drain(0, e, 4, 2, 64'd32975);

        // Capacity 2, keep-max; decimal value 89.
        send(1, 64'd8, 5, 1'b0, st, em);
        send(1, 64'd1, 4, 1'b0, st, em);
        send(1, 64'd8, 3, 1'b0, st, em);
        send(1, 64'd1, 2, 1'b0, st, em);
        chk("t2_one_pop_stall", 64'(st), 64'd1);
        send(1, 64'd9, 1, 1'b1, st, em);
        e = '{64'd8, 64'd9, 64'd0, 64'd0};
        drain(1, e, 2, -1, 64'd89);

        // Capacity 3, keep-min; a mid-sequence mode change must be ignored.
        mode[2] = 1'b1;
        send(2, 64'd5, 5, 1'b0, st, em);
        mode[2] = 1'b0;
        send(2, 64'd3, 4, 1'b0, st, em);
        send(2, 64'd4, 3, 1'b0, st, em);
        send(2, 64'd1, 2, 1'b0, st, em);
        send(2, 64'd2, 1, 1'b1, st, em);
        e = '{64'd3, 64'd1, 64'd2, 64'd0};
        drain(2, e, 3, -1, 64'd312);

        // Keep-max, capacity 4: a large element empties the whole stack.
        send(0, 64'd5, 8, 1'b0, st, em);
        send(0, 64'd4, 7, 1'b0, st, em);
        send(0, 64'd3, 6, 1'b0, st, em);
        send(0, 64'd2, 5, 1'b0, st, em);
        send(0, 64'd9, 4, 1'b0, st, em);
        send(0, 64'd1, 3, 1'b0, st, em);
        chk("t4_stall_cycles", 64'(st), 64'd4);
        chk("t4_empty_cycles", 64'(em), 64'd1);
        send(0, 64'd1, 2, 1'b0, st, em);
        send(0, 64'd1, 1, 1'b1, st, em);
        e = '{64'd9, 64'd1, 64'd1, 64'd1};
        drain(0, e, 4, -1, 64'd9111);

        // Same stream, reset asserted for one cycle while popping.
        send(0, 64'd5, 8, 1'b0, st, em);
        send(0, 64'd4, 7, 1'b0, st, em);
        send(0, 64'd3, 6, 1'b0, st, em);
        send(0, 64'd2, 5, 1'b0, st, em);
        send(0, 64'd9, 4, 1'b0, st, em);
        chk("t6_in_pop", 64'(in_ready[0]), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t6_size", sz(0), 64'd0);
        chk("t6_empty", 64'(empty[0]), 64'd1);
        chk("t6_in_ready", 64'(in_ready[0]), 64'd1);
        chk("t6_out_valid", 64'(out_valid[0]), 64'd0);
        send(0, 64'd30, 6, 1'b0, st, em);
        send(0, 64'd27, 5, 1'b0, st, em);
        send(0, 64'd25, 4, 1'b0, st, em);
        send(0, 64'd20, 3, 1'b0, st, em);
        send(0, 64'd16, 2, 1'b0, st, em);
        send(0, 64'd25, 1, 1'b1, st, em);
        e = '{64'd30, 64'd27, 64'd25, 64'd25};
        drain(0, e, 4, -1, 64'd32975);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
